mas_alu_dispatch: RTL and testbench

//  Command queue and issue controller sitting directly upstream of mas_alu_top.

---
 rtl/mas_alu_dispatch.sv | 188 ++++++++++++++++++
 tb/tb_mas_alu_dispatch.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mas_alu_dispatch.sv
// Command FIFO and single-outstanding issue controller in front of mas_alu_top.
// Commands are issued one at a time; a watchdog aborts an issue the ALU never answers.
package mas_alu_pkg;
  typedef enum logic [2:0] {
    MAS_ADD, MAS_SUB, MAS_AND, MAS_OR, MAS_XOR, MAS_SHL, MAS_SHR, MAS_MUL
  } type_mas_alu_cmd;
endpackage

`ifndef MAS_BLEN
`define MAS_BLEN 16
`endif

module mas_alu_dispatch
  import mas_alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  type_mas_alu_cmd              in_cmd,
  input  logic [`MAS_BLEN-1:0]         in_op1,
  input  logic [`MAS_BLEN-1:0]         in_op2,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         mas_alu_req,
  output type_mas_alu_cmd              mas_alu_cmd,
  output logic [`MAS_BLEN-1:0]         mas_alu_op1,
  output logic [`MAS_BLEN-1:0]         mas_alu_op2,
  input  logic [`MAS_BLEN-1:0]         mas_alu_res,
  input  logic                         mas_alu_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [`MAS_BLEN-1:0]         out_res,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_timeout,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int WDOG_W = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t                state_q, state_d;
  type_mas_alu_cmd       mem_cmd_q [DEPTH];
  logic [`MAS_BLEN-1:0]  mem_op1_q [DEPTH];
  logic [`MAS_BLEN-1:0]  mem_op2_q [DEPTH];
  logic [TAG_W-1:0]      mem_tag_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  in_ready_q, in_ready_d;
  logic                  req_q, req_d;
  type_mas_alu_cmd       cmd_q, cmd_d;
  logic [`MAS_BLEN-1:0]  op1_q, op1_d, op2_q, op2_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic                  out_valid_q, out_valid_d;
  logic [`MAS_BLEN-1:0]  out_res_q, out_res_d;
  logic [TAG_W-1:0]      out_tag_q, out_tag_d;
  logic                  out_timeout_q, out_timeout_d;
  logic                  push, pop;

  assign push = in_valid && in_ready_q;

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    req_d         = req_q;
    cmd_d         = cmd_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    tag_d         = tag_q;
    wdog_d        = wdog_q;
    out_valid_d   = out_valid_q;
    out_res_d     = out_res_q;
    out_tag_d     = out_tag_q;
    out_timeout_d = out_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cmd_d   = mem_cmd_q[rd_ptr_q];
          op1_d   = mem_op1_q[rd_ptr_q];
          op2_d   = mem_op2_q[rd_ptr_q];
          tag_d   = mem_tag_q[rd_ptr_q];
          req_d   = 1'b1;
          wdog_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // ALU completion takes priority over a watchdog expiry on the same edge
        if (mas_alu_ready) begin
          out_res_d     = mas_alu_res;
          out_tag_d     = tag_q;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          req_d         = 1'b0;
          state_d       = S_RESP;
        end else if (wdog_q == WDOG_W'(TIMEOUT-1)) begin
          out_res_d     = '0;
          out_tag_d     = tag_q;
          out_timeout_d = 1'b1;
          out_valid_d   = 1'b1;
          req_d         = 1'b0;
          state_d       = S_RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    in_ready_d = (count_d != CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_cmd_q[wr_ptr_q] <= in_cmd;
      mem_op1_q[wr_ptr_q] <= in_op1;
      mem_op2_q[wr_ptr_q] <= in_op2;
      mem_tag_q[wr_ptr_q] <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b0;
      req_q         <= 1'b0;
      cmd_q         <= type_mas_alu_cmd'('0);
      op1_q         <= '0;
      op2_q         <= '0;
      tag_q         <= '0;
      wdog_q        <= '0;
      out_valid_q   <= 1'b0;
      out_res_q     <= '0;
      out_tag_q     <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q       <= count_d;
      in_ready_q    <= in_ready_d;
      req_q         <= req_d;
      cmd_q         <= cmd_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      tag_q         <= tag_d;
      wdog_q        <= wdog_d;
      out_valid_q   <= out_valid_d;
      out_res_q     <= out_res_d;
      out_tag_q     <= out_tag_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign fifo_count  = count_q;
  assign mas_alu_req = req_q;
  assign mas_alu_cmd = cmd_q;
  assign mas_alu_op1 = op1_q;
  assign mas_alu_op2 = op2_q;
  assign out_valid   = out_valid_q;
  assign out_res     = out_res_q;
  assign out_tag     = out_tag_q;
  assign out_timeout = out_timeout_q;

endmodule

// File: tb/tb_mas_alu_dispatch.sv
// Scoreboard bench for mas_alu_dispatch: a negedge monitor models the FIFO,
// plays the ALU with a per-command latency, and checks every response in order.
`timescale 1ns/1ps
`ifndef MAS_BLEN
`define MAS_BLEN 16
`endif

module tb_mas_alu_dispatch;
  import mas_alu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 255;
  localparam int BL      = `MAS_BLEN;
  localparam int NEVER   = 100000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid, in_ready;
  type_mas_alu_cmd      in_cmd;
  logic [BL-1:0]        in_op1, in_op2;
  logic [TAG_W-1:0]     in_tag;
  logic                 mas_alu_req;
  type_mas_alu_cmd      mas_alu_cmd;
  logic [BL-1:0]        mas_alu_op1, mas_alu_op2, mas_alu_res;
  logic                 mas_alu_ready;
  logic                 out_valid, out_ready;
  logic [BL-1:0]        out_res;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_timeout;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;

  mas_alu_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .mas_alu_req(mas_alu_req), .mas_alu_cmd(mas_alu_cmd),
    .mas_alu_op1(mas_alu_op1), .mas_alu_op2(mas_alu_op2),
    .mas_alu_res(mas_alu_res), .mas_alu_ready(mas_alu_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_tag(out_tag), .out_timeout(out_timeout), .fifo_count(fifo_count)
  );

  typedef struct {
    type_mas_alu_cmd  cmd;
    logic [BL-1:0]    op1, op2;
    logic [TAG_W-1:0] tag;
    int unsigned      lat;
  } cmd_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [BL-1:0]    res;
    logic             tmo;
    int unsigned      reqcyc;
  } rsp_t;

  cmd_t pend[$];
  rsp_t sb[$];
  cmd_t cur;
  rsp_t exp_r;
  int unsigned in_lat;
  int unsigned k, reqcnt;
  logic req_prev, rst_prev, held, rand_or;
  logic [BL-1:0]    held_res;
  logic [TAG_W-1:0] held_tag;
  logic             held_tmo;
  int checks = 0;
  int failures = 0;

  function automatic logic [BL-1:0] ref_alu(type_mas_alu_cmd c, logic [BL-1:0] a, logic [BL-1:0] b);
    case (c)
      MAS_ADD: return BL'(a + b);
      MAS_SUB: return BL'(a - b);
      MAS_AND: return a & b;
      MAS_OR:  return a | b;
      MAS_XOR: return a ^ b;
      MAS_SHL: return a << b[3:0];
      MAS_SHR: return a >> b[3:0];
      default: return BL'(a * b);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=completion at %0t", name, $time);
  endtask

  // Reference model, ALU responder and response checker
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      sb.delete();
      req_prev      = 1'b0;
      held          = 1'b0;
      rst_prev      = 1'b1;
      k             = 0;
      reqcnt        = 0;
      mas_alu_ready = 1'b0;
      mas_alu_res   = '0;
    end else begin
      if (mas_alu_req && !req_prev) begin
        if (pend.size() == 0) begin
          bound_fail("issue_from_empty");
        end else begin
          cur = pend.pop_front();
          chk("issue_cmd", 32'(mas_alu_cmd), 32'(cur.cmd));
          chk("issue_op1", 32'(mas_alu_op1), 32'(cur.op1));
          chk("issue_op2", 32'(mas_alu_op2), 32'(cur.op2));
        end
        k = 1;
        reqcnt = 1;
      end else if (mas_alu_req) begin
        k++;
        reqcnt++;
      end
      req_prev = mas_alu_req;
      if (mas_alu_req) begin
        mas_alu_ready = (k == cur.lat);
        mas_alu_res   = ref_alu(mas_alu_cmd, mas_alu_op1, mas_alu_op2);
      end else begin
        mas_alu_ready = 1'($urandom_range(0, 1));
        mas_alu_res   = BL'($urandom);
      end

      chk("fifo_count", 32'(fifo_count), 32'(pend.size()));
      if (!rst_prev) chk("in_ready", 32'(in_ready), 32'(pend.size() != DEPTH));

      if (in_valid && in_ready) begin
        pend.push_back('{in_cmd, in_op1, in_op2, in_tag, in_lat});
        if (in_lat <= TIMEOUT)
          sb.push_back('{in_tag, ref_alu(in_cmd, in_op1, in_op2), 1'b0, in_lat});
        else
          sb.push_back('{in_tag, '0, 1'b1, TIMEOUT});
      end

      if (out_valid) begin
        chk("req_low_in_resp", 32'(mas_alu_req), 32'd0);
        if (held) begin
          chk("hold_res", 32'(out_res), 32'(held_res));
          chk("hold_tag", 32'(out_tag), 32'(held_tag));
          chk("hold_tmo", 32'(out_timeout), 32'(held_tmo));
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            bound_fail("unexpected_response");
          end else begin
            exp_r = sb.pop_front();
            chk("rsp_tag", 32'(out_tag), 32'(exp_r.tag));
            chk("rsp_res", 32'(out_res), 32'(exp_r.res));
            chk("rsp_timeout", 32'(out_timeout), 32'(exp_r.tmo));
            chk("rsp_req_cycles", reqcnt, exp_r.reqcyc);
          end
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_res = out_res;
          held_tag = out_tag;
          held_tmo = out_timeout;
        end
      end else begin
        held = 1'b0;
      end
      rst_prev = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic push(input type_mas_alu_cmd c, input logic [BL-1:0] a, input logic [BL-1:0] b,
                      input logic [TAG_W-1:0] t, input int unsigned lat);
    bit done = 0;
    in_valid = 1'b1;
    in_cmd = c; in_op1 = a; in_op2 = b; in_tag = t; in_lat = lat;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) bound_fail("push_accept");
  endtask

  task automatic drain(input int unsigned max_cyc);
    bit done = 0;
    for (int i = 0; i < int'(max_cyc) && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && pend.size() == 0 && !out_valid && !mas_alu_req) done = 1;
    end
    if (!done) bound_fail("drain");
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    in_valid = 1'b0; in_cmd = MAS_ADD; in_op1 = '0; in_op2 = '0; in_tag = '0;
    in_lat = 1; out_ready = 1'b0; rand_or = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mas_alu_req), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_out_res", 32'(out_res), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_out_timeout", 32'(out_timeout), 0);
    chk("rst_alu_op1", 32'(mas_alu_op1), 0);
    rst_n = 1'b1;
    chk("in_ready_at_release", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("in_ready_after_release", 32'(in_ready), 1);

    // single op: ADD 5+3, ALU answers on the third issue cycle
    out_ready = 1'b1;
    push(MAS_ADD, BL'(5), BL'(3), TAG_W'(2), 3);
    drain(100);

    // fill while the consumer stalls, then hold backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_cmd = type_mas_alu_cmd'(3'($urandom_range(0, 7)));
      in_op1 = BL'($urandom); in_op2 = BL'($urandom);
      in_tag = TAG_W'(i); in_lat = 2;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("fill_count", 32'(fifo_count), DEPTH);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_out_valid", 32'(out_valid), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_count", 32'(fifo_count), DEPTH);
    chk("bp_req", 32'(mas_alu_req), 0);
    rand_or = 1'b1;
    drain(400);

    // watchdog abort, then a normal op; exact tie; one short of the limit
    push(MAS_SUB, BL'($urandom), BL'($urandom), TAG_W'(7), NEVER);
    push(MAS_XOR, BL'($urandom), BL'($urandom), TAG_W'(8), 4);
    push(MAS_MUL, BL'($urandom), BL'($urandom), TAG_W'(9), TIMEOUT);
    push(MAS_OR,  BL'($urandom), BL'($urandom), TAG_W'(10), TIMEOUT - 1);
    push(MAS_AND, BL'($urandom), BL'($urandom), TAG_W'(11), TIMEOUT + 1);
    drain(3000);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int unsigned lat;
      lat = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) != 0) ? TIMEOUT : NEVER)
                                        : $urandom_range(1, 6);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
      push(type_mas_alu_cmd'(3'($urandom_range(0, 7))), BL'($urandom), BL'($urandom),
           TAG_W'($urandom), lat);
    end
    drain(5000);

    // asynchronous reset in the middle of an issue
    push(MAS_ADD, BL'(1), BL'(2), TAG_W'(3), NEVER);
    push(MAS_SUB, BL'(9), BL'(4), TAG_W'(4), 2);
    begin
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (mas_alu_req) seen = 1;
      end
      if (!seen) bound_fail("wait_issue");
    end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(mas_alu_req), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_fifo_count", 32'(fifo_count), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready_after", 32'(in_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_stale_ready_req", 32'(mas_alu_req), 0);
    chk("midrst_stale_ready_valid", 32'(out_valid), 0);
    push(MAS_SHL, BL'(3), BL'(4), TAG_W'(5), 1);
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
